// File: rtl/tx_channel_gen.sv
// tx_channel_gen: PRBS9 BPSK symbol source driving a programmable 3-tap ISI
// channel. It emits saturated fixed-point samples for the equalizer input,
// plus a delay-aligned reference bit for bit-for-bit decision checking.
module tx_channel_gen #(
  parameter int NBout   = 8,
  parameter int NBFout  = 5,
  parameter int NBh     = 7,
  parameter int NBFh    = 5,
  parameter int REF_DLY = 4
) (
  input  logic                    clkA,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [3*NBh-1:0]        h,
  output logic signed [NBout-1:0] x,
  output logic                    sym,
  output logic                    valid,
  output logic                    d_ref
);

  // Accumulator: two guard bits cover three taps of full-scale magnitude,
  // including the negation of the most negative tap value.
  localparam int AW = NBh + 2;
  // Alignment shift from the tap fraction to the output fraction.
  localparam int SH = NBFout - NBFh;
  localparam int SW = AW + SH;
  // Compare width is wide enough for both the shifted sum and the output
  // range, plus a sign bit, so the clamp comparison never wraps.
  localparam int CW = ((SW > NBout) ? SW : NBout) + 1;

  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-NBout+1){1'b0}}, {(NBout-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  logic [8:0]              lfsr;
  logic                    hist0;
  logic                    hist1;
  logic [1:0]              fill;
  logic [REF_DLY-1:0]      dref_sr;

  logic                    new_bit;
  logic signed [AW-1:0]    tap0;
  logic signed [AW-1:0]    tap1;
  logic signed [AW-1:0]    tap2;
  logic signed [AW-1:0]    term0;
  logic signed [AW-1:0]    term1;
  logic signed [AW-1:0]    term2;
  logic signed [AW-1:0]    acc;
  logic signed [CW-1:0]    acc_ext;
  logic signed [CW-1:0]    wide;
  logic signed [NBout-1:0] sat;

  assign new_bit = lfsr[8] ^ lfsr[4];
  assign d_ref   = dref_sr[REF_DLY-1];

  // Channel sum for the symbol about to be emitted. Taps are sign-extended
  // before negation; history entries not yet filled since reset add zero.
  always_comb begin
    tap0    = {{2{h[NBh-1]}},   h[NBh-1:0]};
    tap1    = {{2{h[2*NBh-1]}}, h[2*NBh-1:NBh]};
    tap2    = {{2{h[3*NBh-1]}}, h[3*NBh-1:2*NBh]};
    term0   = new_bit ? tap0 : -tap0;
    term1   = '0;
    term2   = '0;
    if (fill >= 2'd1) term1 = hist0 ? tap1 : -tap1;
    if (fill >= 2'd2) term2 = hist1 ? tap2 : -tap2;
    acc     = term0 + term1 + term2;
    acc_ext = {{(CW-AW){acc[AW-1]}}, acc};
    wide    = acc_ext <<< SH;
    if (wide > SAT_MAX)      sat = SAT_MAX[NBout-1:0];
    else if (wide < SAT_MIN) sat = SAT_MIN[NBout-1:0];
    else                     sat = wide[NBout-1:0];
  end

  // Generator state: advances one symbol per enabled edge, holds otherwise.
  always_ff @(posedge clkA) begin
    if (reset) begin
      lfsr  <= 9'h1FF;
      hist0 <= 1'b0;
      hist1 <= 1'b0;
      fill  <= 2'd0;
      x     <= '0;
      sym   <= 1'b0;
      valid <= 1'b0;
    end else if (enable) begin
      lfsr  <= {lfsr[7:0], new_bit};
      x     <= sat;
      sym   <= new_bit;
      hist1 <= hist0;
      hist0 <= new_bit;
      if (fill != 2'd2) fill <= fill + 2'd1;
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

  // Free-running reference delay line of sym, independent of enable.
  always_ff @(posedge clkA) begin
    if (reset) begin
      dref_sr <= '0;
    end else begin
      dref_sr[0] <= sym;
      for (int i = 1; i < REF_DLY; i++) dref_sr[i] <= dref_sr[i-1];
    end
  end

endmodule

// File: tb/tb_tx_channel_gen.sv
// Self-checking bench for tx_channel_gen at default parameters.
module tb_tx_channel_gen;

  logic               clkA = 1'b0;
  logic               reset;
  logic               enable;
  logic [20:0]        h;
  logic signed [7:0]  x;
  logic               sym;
  logic               valid;
  logic               d_ref;

  int vectors     = 0;
  int miscompares = 0;

  bit ref_bits [1:1100];

  tx_channel_gen #(
    .NBout(8), .NBFout(5), .NBh(7), .NBFh(5), .REF_DLY(4)
  ) dut (
    .clkA(clkA), .reset(reset), .enable(enable), .h(h),
    .x(x), .sym(sym), .valid(valid), .d_ref(d_ref)
  );

  always #5 clkA = ~clkA;

  function automatic void build_bits();
    logic [8:0] s;
    logic b;
    s = 9'h1FF;
    for (int k = 1; k <= 1100; k++) begin
      b = s[8] ^ s[4];
      ref_bits[k] = b;
      s = {s[7:0], b};
    end
  endfunction

  function automatic int model_x(int k, int h0, int h1, int h2);
    int acc;
    acc = ref_bits[k] ? h0 : -h0;
    if (k >= 2) acc += ref_bits[k-1] ? h1 : -h1;
    if (k >= 3) acc += ref_bits[k-2] ? h2 : -h2;
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic set_taps(int h0, int h1, int h2);
    h = {7'(h2), 7'(h1), 7'(h0)};
  endtask

  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    set_taps(32, 0, 0);
    tick();
    tick();
    vectors++;
    if (x !== 8'sd0) begin miscompares++; $display("[TB] FAIL reset_x: got %0d expected 0", x); end
    vectors++;
    if (sym !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sym: got %0b expected 0", sym); end
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid); end
    vectors++;
    if (d_ref !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dref: got %0b expected 0", d_ref); end
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_cursor();
    int cx [10] = '{-32, -32, -32, -32, -32, 32, 32, 32, 32, -32};
    bit cs [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int idx;
    bit exp_ref;
    apply_reset();
    set_taps(32, 0, 0);
    enable = 1'b1;
    for (int k = 1; k <= 521; k++) begin
      tick();
      if (k <= 10 || k >= 512) begin
        idx = (k <= 10) ? k - 1 : k - 512;
        vectors++;
        if (x !== 8'(cx[idx])) begin
          miscompares++;
          $display("[TB] FAIL cursor_x[%0d]: got %0d expected %0d", k, x, cx[idx]);
        end
        vectors++;
        if (sym !== cs[idx]) begin
          miscompares++;
          $display("[TB] FAIL cursor_sym[%0d]: got %0b expected %0b", k, sym, cs[idx]);
        end
      end
      if (k <= 30) begin
        exp_ref = (k > 4) ? ref_bits[k-4] : 1'b0;
        vectors++;
        if (d_ref !== exp_ref) begin
          miscompares++;
          $display("[TB] FAIL ref_delay[%0d]: got %0b expected %0b", k, d_ref, exp_ref);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_history();
    apply_reset();
    set_taps(0, 32, 0);
    enable = 1'b1;
    tick();
    vectors++;
    if (x !== 8'sd0) begin miscompares++; $display("[TB] FAIL hist_h1_first: got %0d expected 0", x); end
    tick();
    vectors++;
    if (x !== -8'sd32) begin miscompares++; $display("[TB] FAIL hist_h1_second: got %0d expected -32", x); end
    apply_reset();
    set_taps(0, 0, 32);
    enable = 1'b1;
    tick();
    vectors++;
    if (x !== 8'sd0) begin miscompares++; $display("[TB] FAIL hist_h2_first: got %0d expected 0", x); end
    tick();
    vectors++;
    if (x !== 8'sd0) begin miscompares++; $display("[TB] FAIL hist_h2_second: got %0d expected 0", x); end
    tick();
    vectors++;
    if (x !== -8'sd32) begin miscompares++; $display("[TB] FAIL hist_h2_third: got %0d expected -32", x); end
    enable = 1'b0;
  endtask

  task automatic test_saturation();
    int pos [10] = '{-63, -126, -128, -128, -128, -63, 63, 127, 127, 63};
    int neg [10] = '{64, 127, 127, 127, 127, 64, -64, -128, -128, -64};
    apply_reset();
    set_taps(63, 63, 63);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (x !== 8'(pos[k])) begin
        miscompares++;
        $display("[TB] FAIL sat_pos[%0d]: got %0d expected %0d", k + 1, x, pos[k]);
      end
    end
    apply_reset();
    set_taps(-64, -64, -64);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (x !== 8'(neg[k])) begin
        miscompares++;
        $display("[TB] FAIL sat_neg[%0d]: got %0d expected %0d", k + 1, x, neg[k]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_gaps();
    int n;
    int ex;
    bit en;
    apply_reset();
    set_taps(24, -12, 6);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      en = (c % 3 == 0);
      enable = en;
      tick();
      if (en) n++;
      ex = model_x(n, 24, -12, 6);
      vectors++;
      if (valid !== en) begin
        miscompares++;
        $display("[TB] FAIL gap_valid[%0d]: got %0b expected %0b", c, valid, en);
      end
      vectors++;
      if (x !== 8'(ex)) begin
        miscompares++;
        $display("[TB] FAIL gap_x[%0d]: got %0d expected %0d", c, x, ex);
      end
      vectors++;
      if (sym !== ref_bits[n]) begin
        miscompares++;
        $display("[TB] FAIL gap_sym[%0d]: got %0b expected %0b", c, sym, ref_bits[n]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int ex;
    apply_reset();
    set_taps(32, 0, 0);
    enable = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    ex = model_x(100, 32, 0, 0);
    vectors++;
    if (x !== 8'(ex)) begin miscompares++; $display("[TB] FAIL midrun_x100: got %0d expected %0d", x, ex); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (x !== 8'sd0) begin miscompares++; $display("[TB] FAIL midrun_rst_x: got %0d expected 0", x); end
    vectors++;
    if (sym !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_rst_sym: got %0b expected 0", sym); end
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_rst_valid: got %0b expected 0", valid); end
    vectors++;
    if (d_ref !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_rst_dref: got %0b expected 0", d_ref); end
    tick();
    vectors++;
    if (x !== -8'sd32) begin miscompares++; $display("[TB] FAIL midrun_first_x: got %0d expected -32", x); end
    vectors++;
    if (sym !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_first_sym: got %0b expected 0", sym); end
    vectors++;
    if (valid !== 1'b1) begin miscompares++; $display("[TB] FAIL midrun_first_valid: got %0b expected 1", valid); end
    enable = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    h      = '0;
    build_bits();
    test_reset();
    test_cursor();
    test_history();
    test_saturation();
    test_gaps();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
